// File: rtl/commit_monitor_pkg.sv
// Shared types and default parameter values for the commit monitor slice.
package commit_monitor_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        HUNG   = 2'd2
    } mon_state_e;

    localparam int unsigned DEF_LANES       = 2;
    localparam int unsigned DEF_ORDER_W     = 64;
    localparam int unsigned DEF_HALT_REPEAT = 2;
    localparam int unsigned DEF_WDOG_CYCLES = 1024;
    localparam int unsigned PC_W            = 32;
    localparam int unsigned CNT_W           = 3;

endpackage

// File: rtl/commit_lane_scan.sv
// Combinational per-cycle scan of the commit lanes: contiguity, popcount,
// per-lane order offsets and self-loop branch detection.
module commit_lane_scan
    import commit_monitor_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic [LANES-1:0]                 commit_valid,
    input  logic [LANES-1:0][PC_W-1:0]       commit_pc,
    input  logic [LANES-1:0][PC_W-1:0]       commit_next_pc,
    input  logic [LANES-1:0]                 commit_is_branch,
    output logic                             legal,
    output logic [CNT_W-1:0]                 popcnt,
    output logic [LANES-1:0][CNT_W-1:0]      offset,
    output logic [LANES-1:0]                 self_loop
);

    logic gap;

    // A valid lane above any idle lane breaks contiguity from lane 0.
    always_comb begin
        legal     = 1'b1;
        gap       = 1'b0;
        popcnt    = '0;
        offset    = '0;
        self_loop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            offset[i] = popcnt;
            if (commit_valid[i]) begin
                if (gap) begin
                    legal = 1'b0;
                end
                popcnt = popcnt + CNT_W'(1);
            end else begin
                gap = 1'b1;
            end
            self_loop[i] = commit_valid[i] & commit_is_branch[i] &
                           (commit_next_pc[i] == commit_pc[i]);
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: numbers committed instructions and flags self-loop
// halts, commit watchdog expiry and malformed commit strobes.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int unsigned LANES       = DEF_LANES,
    parameter int unsigned ORDER_W     = DEF_ORDER_W,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              commit_valid,
    input  logic [LANES-1:0][PC_W-1:0]    commit_pc,
    input  logic [LANES-1:0][PC_W-1:0]    commit_next_pc,
    input  logic [LANES-1:0]              commit_is_branch,
    input  logic                          flush,
    output logic [LANES-1:0]              mon_commit,
    output logic [LANES-1:0][ORDER_W-1:0] mon_order,
    output logic                          halt,
    output logic                          hang,
    output logic                          proto_err
);

    localparam int unsigned LOOP_W = $clog2(HALT_REPEAT + 1);
    localparam int unsigned WD_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(HALT_REPEAT);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(WDOG_CYCLES);

    mon_state_e                   state, state_nxt;
    logic [ORDER_W-1:0]           order_cnt, order_nxt;
    logic [LOOP_W-1:0]            loop_cnt, loop_nxt;
    logic [WD_W-1:0]              wdog_cnt, wdog_nxt;
    logic [LANES-1:0][ORDER_W-1:0] mon_order_nxt;

    logic                         legal;
    logic [CNT_W-1:0]             popcnt;
    logic [LANES-1:0][CNT_W-1:0]  offset;
    logic [LANES-1:0]             self_loop;
    logic                         illegal, accept, loop_hit, wdog_hit;

    commit_lane_scan #(
        .LANES (LANES)
    ) u_scan (
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_next_pc   (commit_next_pc),
        .commit_is_branch (commit_is_branch),
        .legal            (legal),
        .popcnt           (popcnt),
        .offset           (offset),
        .self_loop        (self_loop)
    );

    assign illegal = (commit_valid != '0) && !legal;
    assign accept  = (state == RUN) && legal && (commit_valid != '0);

    // Flush clears first; lanes are then walked oldest to youngest.
    always_comb begin
        loop_nxt = flush ? '0 : loop_cnt;
        loop_hit = 1'b0;
        if (accept) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (commit_valid[i]) begin
                    if (self_loop[i]) begin
                        if (loop_nxt != LOOP_MAX) begin
                            loop_nxt = loop_nxt + LOOP_W'(1);
                        end
                        if (loop_nxt == LOOP_MAX) begin
                            loop_hit = 1'b1;
                        end
                    end else begin
                        loop_nxt = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        wdog_nxt = wdog_cnt;
        if (state == RUN) begin
            if (accept) begin
                wdog_nxt = '0;
            end else if (wdog_cnt != WD_MAX) begin
                wdog_nxt = wdog_cnt + WD_W'(1);
            end
        end
        wdog_hit = (state == RUN) && !accept && (wdog_nxt == WD_MAX);
    end

    always_comb begin
        order_nxt     = accept ? order_cnt + ORDER_W'(popcnt) : order_cnt;
        mon_order_nxt = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (accept && commit_valid[i]) begin
                mon_order_nxt[i] = order_cnt + ORDER_W'(offset[i]);
            end
        end
    end

    // Halt takes priority over the watchdog on a coincident edge.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (loop_hit) begin
                    state_nxt = HALTED;
                end else if (wdog_hit) begin
                    state_nxt = HUNG;
                end
            end
            HALTED:  state_nxt = HALTED;
            HUNG:    state_nxt = HUNG;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            order_cnt  <= '0;
            loop_cnt   <= '0;
            wdog_cnt   <= '0;
            proto_err  <= 1'b0;
            mon_commit <= '0;
            mon_order  <= '0;
        end else begin
            state      <= state_nxt;
            order_cnt  <= order_nxt;
            loop_cnt   <= loop_nxt;
            wdog_cnt   <= wdog_nxt;
            if (illegal) begin
                proto_err <= 1'b1;
            end
            mon_commit <= accept ? commit_valid : '0;
            mon_order  <= mon_order_nxt;
        end
    end

    always_comb begin
        halt = (state == HALTED);
        hang = (state == HUNG);
    end

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: directed table, hand sequences for
// watchdog and order wrap, and randomized traffic against a reference model.
module tb_commit_monitor;

    localparam int LN = 2;
    localparam int OW = 4;
    localparam int HR = 2;
    localparam int WD = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [LN-1:0]        commit_valid = '0;
    logic [LN-1:0][31:0]  commit_pc = '0;
    logic [LN-1:0][31:0]  commit_next_pc = '0;
    logic [LN-1:0]        commit_is_branch = '0;
    logic                 flush = 1'b0;
    logic [LN-1:0]        mon_commit;
    logic [LN-1:0][OW-1:0] mon_order;
    logic                 halt, hang, proto_err;

    commit_monitor #(
        .LANES       (LN),
        .ORDER_W     (OW),
        .HALT_REPEAT (HR),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_next_pc   (commit_next_pc),
        .commit_is_branch (commit_is_branch),
        .flush            (flush),
        .mon_commit       (mon_commit),
        .mon_order        (mon_order),
        .halt             (halt),
        .hang             (hang),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counters as plain integers, flags as bits.
    int         m_order, m_loop, m_wd;
    bit         m_halt, m_hung, m_proto, m_rst;
    logic [1:0] m_commit;
    int         m_o [LN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic [1:0] v, input logic [1:0] sl, input logic fl);
        int n;
        bit legal, run, acc, hit;
        m_rst = !r;
        if (!r) begin
            m_order = 0; m_loop = 0; m_wd = 0;
            m_halt = 0; m_hung = 0; m_proto = 0;
            m_commit = '0;
            for (int i = 0; i < LN; i++) m_o[i] = 0;
            return;
        end
        n     = int'(v[0]) + int'(v[1]);
        legal = (int'(v) == (1 << n) - 1);
        run   = !m_halt && !m_hung;
        if (v != 0 && !legal) m_proto = 1;
        acc      = run && legal && (v != 0);
        m_commit = acc ? v : 2'b00;
        for (int i = 0; i < LN; i++) m_o[i] = (m_order + i) % (1 << OW);
        if (fl) m_loop = 0;
        hit = 0;
        if (acc) begin
            for (int i = 0; i < LN; i++) begin
                if (v[i]) begin
                    if (sl[i]) begin
                        if (m_loop < HR) m_loop++;
                        if (m_loop == HR) hit = 1;
                    end else begin
                        m_loop = 0;
                    end
                end
            end
        end
        if (run) begin
            if (acc) m_wd = 0;
            else if (m_wd < WD) m_wd++;
        end
        if (acc) m_order = (m_order + n) % (1 << OW);
        if (run && hit) m_halt = 1;
        else if (run && !acc && m_wd == WD) m_hung = 1;
    endtask

    task automatic compare_model();
        chk("mon_commit", 32'(mon_commit), 32'(m_commit));
        for (int i = 0; i < LN; i++) begin
            if (m_commit[i] || m_rst) chk($sformatf("mon_order%0d", i), 32'(mon_order[i]),
                                          m_rst ? 32'd0 : 32'(m_o[i]));
        end
        chk("halt", 32'(halt), 32'(m_halt));
        chk("hang", 32'(hang), 32'(m_hung));
        chk("proto_err", 32'(proto_err), 32'(m_proto));
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input logic r, input logic [1:0] v, input logic [1:0] br,
                         input logic [1:0] eq, input logic fl);
        logic [1:0] sl;
        rst = r; commit_valid = v; commit_is_branch = br; flush = fl;
        for (int i = 0; i < LN; i++) begin
            commit_pc[i]      = ($urandom & 32'hFFFF_FFFC);
            commit_next_pc[i] = eq[i] ? commit_pc[i] : commit_pc[i] + 32'd4;
        end
        sl = v & br & eq;
        model(r, v, sl, fl);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       r;
        logic [1:0] v, br, eq;
        logic       fl;
        logic [1:0] e_commit;
        logic [3:0] e_o0, e_o1;
        logic       e_halt, e_hang, e_proto;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl = '{
            '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 4'd2,  4'd3, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 4'd4,  4'd5, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 4'd6,  4'd0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd7,  4'd0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 4'd8,  4'd0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd9,  4'd0, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd10, 4'd0, 1'b1, 1'b0, 1'b1},
            '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0, 2'b11, 4'd0,  4'd1, 1'b1, 1'b0, 1'b0},
            '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 4'd1,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 2'b01, 4'd2,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd3,  4'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 4'd4,  4'd0, 1'b1, 1'b0, 1'b0}
        };

        // Directed table: ordering, proto error, halt detection, flush.
        for (int k = 0; k < 19; k++) begin
            cycle(tbl[k].r, tbl[k].v, tbl[k].br, tbl[k].eq, tbl[k].fl);
            chk($sformatf("tbl%0d.commit", k), 32'(mon_commit), 32'(tbl[k].e_commit));
            if (tbl[k].e_commit[0]) chk($sformatf("tbl%0d.o0", k), 32'(mon_order[0]), 32'(tbl[k].e_o0));
            if (tbl[k].e_commit[1]) chk($sformatf("tbl%0d.o1", k), 32'(mon_order[1]), 32'(tbl[k].e_o1));
            chk($sformatf("tbl%0d.halt", k), 32'(halt), 32'(tbl[k].e_halt));
            chk($sformatf("tbl%0d.hang", k), 32'(hang), 32'(tbl[k].e_hang));
            chk($sformatf("tbl%0d.proto", k), 32'(proto_err), 32'(tbl[k].e_proto));
        end

        // Watchdog: commit on the 7th idle-slot restarts the count.
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
        chk("wd_restart_hang", 32'(hang), 32'd0);
        for (int k = 0; k < 7; k++) cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        chk("wd_7idle_hang", 32'(hang), 32'd0);
        cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        chk("wd_8idle_hang", 32'(hang), 32'd1);
        cycle(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
        chk("hung_no_commit", 32'(mon_commit), 32'd0);

        // Order wrap at ORDER_W=4, then reset mid-stream.
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 17; k++) begin
            cycle(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
            chk($sformatf("wrap%0d", k), 32'(mon_order[0]), 32'(k % 16));
        end
        cycle(1'b0, 2'b11, 2'b11, 2'b11, 1'b1);
        chk("rst_outputs", {mon_commit, mon_order, halt, hang, proto_err}, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic r;
            logic [1:0] v;
            r = ($urandom_range(0, 39) != 0);
            v = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            cycle(r, v, 2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
